hazard_forward_ctrl: RTL and testbench

Next-generation hazard unit for the 5-stage RV32 pipeline. It merges operand forwarding and load-use/memory-wait stall control into one block.
- Forwarding covers a parametrised number of source operands per instruction (NUM_RS).
- A parametrised load-use penalty supports deeper memory stages.
- A multi-cycle data-memory wait freezes the whole pipeline.
- Sits beside the ID/EX and EX/MEM registers. Drives the EX operand muxes and the PC/IF-ID/ID-EX enables.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_forward_ctrl_fwd_select.sv | 47 ++++
 rtl/hazard_forward_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the RV32 hazard unit.
//                - Forwarding mux codes.
//                - Hazard FSM state encoding.
//                - Default register address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int RA_W_DEFAULT = 5;

  // EX operand mux select codes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Forwarding comparator and priority mux for one EX operand.
//                EX/MEM wins over MEM/WB. x0 never forwards. A load in EX/MEM
//                has no data yet, so it is not a forwarding source.
//  Ports       : ex_rs_i          - ID/EX source register address
//                mem_rd_i         - EX/MEM destination register
//                mem_reg_write_i  - EX/MEM RegWrite
//                mem_mem_read_i   - EX/MEM MemRead
//                wb_rd_i          - MEM/WB destination register
//                wb_reg_write_i   - MEM/WB RegWrite
//                sel_o            - operand mux select (FWD_* code)
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic [RA_W-1:0] ex_rs_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic            mem_mem_read_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_reg_write_i,
  output logic [1:0]      sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) &&
                   (mem_rd_i == ex_rs_i) && !mem_mem_read_i;
  assign wb_hit  = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_ctrl
//  Description : Combined forwarding and stall control for the 5-stage RV32
//                pipeline: per-operand forwarding selects, load-use bubbles
//                (LU_PENALTY per hazard), data-memory wait freeze and a
//                saturating stall statistics counter.
//  Ports       : clk, rst_n             - clock / async active-low reset
//                id_rs_addr, id_rs_used - IF/ID source operands
//                ex_rs_addr, ex_rd, ex_reg_write, ex_mem_read - ID/EX info
//                mem_rd, mem_reg_write, mem_mem_read, mem_ready - EX/MEM info
//                wb_rd, wb_reg_write    - MEM/WB info
//                branch_flush           - taken branch resolved in EX
//                stat_clr               - clear stall_cycles
//                forward_sel            - per-operand EX mux selects
//                pc_write_en, ifid_write_en, idex_bubble, pipe_freeze
//                stall_cycles           - cycles with pc_write_en low
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W       = RA_W_DEFAULT,
  parameter int NUM_RS     = 2,
  parameter int LU_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RS*RA_W-1:0] id_rs_addr,
  input  logic [NUM_RS-1:0]      id_rs_used,
  input  logic [NUM_RS*RA_W-1:0] ex_rs_addr,
  input  logic [RA_W-1:0]        ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [RA_W-1:0]        mem_rd,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_read,
  input  logic                   mem_ready,
  input  logic [RA_W-1:0]        wb_rd,
  input  logic                   wb_reg_write,
  input  logic                   branch_flush,
  input  logic                   stat_clr,
  output logic [NUM_RS*2-1:0]    forward_sel,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   idex_bubble,
  output logic                   pipe_freeze,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam logic [2:0]       LU_RELOAD = 3'(LU_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  hz_state_e        state_q, state_d, state_eff;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic src_match;
  logic lu_hz;
  logic freeze_req;
  logic pc_en_d, ifid_en_d, bubble_d, freeze_d;

  // --------------------------------------------------------------------------
  // Forwarding: one comparator/mux per source operand
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_RS; g++) begin : g_fwd
    fwd_select #(.RA_W(RA_W)) u_fwd_select (
      .ex_rs_i         (ex_rs_addr[g*RA_W +: RA_W]),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_reg_write),
      .mem_mem_read_i  (mem_mem_read),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_reg_write),
      .sel_o           (forward_sel[g*2 +: 2])
    );
  end

  // --------------------------------------------------------------------------
  // Load-use detection
  // --------------------------------------------------------------------------
  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (id_rs_used[i] && (id_rs_addr[i*RA_W +: RA_W] == ex_rd)) begin
        src_match = 1'b1;
      end
    end
  end

  assign lu_hz      = ex_mem_read && ex_reg_write && (ex_rd != '0) && src_match;
  assign freeze_req = mem_mem_read && !mem_ready;

  // --------------------------------------------------------------------------
  // Stall FSM (Mealy outputs)
  // --------------------------------------------------------------------------
  // Leaving MEM_WAIT happens in the same cycle mem_ready rises, so that cycle
  // already behaves like the state being resumed (pending bubbles or RUN).
  always_comb begin
    state_eff = state_q;
    if (state_q == MEM_WAIT) begin
      state_eff = (lu_cnt_q != 3'd0) ? LU_STALL : RUN;
    end
  end

  always_comb begin
    state_d   = state_eff;
    lu_cnt_d  = lu_cnt_q;
    pc_en_d   = 1'b1;
    ifid_en_d = 1'b1;
    bubble_d  = 1'b0;
    freeze_d  = 1'b0;

    if (freeze_req) begin
      // Whole pipe holds; pending bubble count and any flush in EX survive.
      freeze_d  = 1'b1;
      pc_en_d   = 1'b0;
      ifid_en_d = 1'b0;
      state_d   = MEM_WAIT;
    end else begin
      case (state_eff)
        RUN: begin
          if (!branch_flush && lu_hz) begin
            bubble_d  = 1'b1;
            pc_en_d   = 1'b0;
            ifid_en_d = 1'b0;
            if (LU_PENALTY > 1) begin
              lu_cnt_d = LU_RELOAD;
              state_d  = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          if (branch_flush) begin
            // The stalled ID instruction is being squashed anyway.
            lu_cnt_d = 3'd0;
            state_d  = RUN;
          end else begin
            bubble_d  = 1'b1;
            pc_en_d   = 1'b0;
            ifid_en_d = 1'b0;
            lu_cnt_d  = lu_cnt_q - 3'd1;
            if (lu_cnt_q <= 3'd1) begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Reset forces the pipeline-control outputs to their free-running values
  // immediately, independent of the clock.
  assign pc_write_en   = pc_en_d   || !rst_n;
  assign ifid_write_en = ifid_en_d || !rst_n;
  assign idex_bubble   = bubble_d  && rst_n;
  assign pipe_freeze   = freeze_d  && rst_n;

  // --------------------------------------------------------------------------
  // Stall statistics
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stat_clr) begin
      stall_cycles_d = '0;
    end else if (!pc_write_en && (stall_cycles_q != CNT_SAT)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      lu_cnt_q       <= 3'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_ctrl
//  Description : Directed self-checking bench. Two instances share stimulus:
//                u_p1 (LU_PENALTY=1, CNT_W=16) and u_p3 (LU_PENALTY=3,
//                CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs_addr;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_ready;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        branch_flush;
  logic        stat_clr;

  logic [3:0]  fs1, fs3;
  logic        pc1, if1, bub1, frz1;
  logic        pc3, if3, bub3, frz3;
  logic [15:0] sc1;
  logic [3:0]  sc3;

  int n_checks = 0;
  int n_fail   = 0;
  int nb;

  hazard_forward_ctrl #(.RA_W(5), .NUM_RS(2), .LU_PENALTY(1), .CNT_W(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_ready(mem_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .branch_flush(branch_flush), .stat_clr(stat_clr),
    .forward_sel(fs1), .pc_write_en(pc1), .ifid_write_en(if1),
    .idex_bubble(bub1), .pipe_freeze(frz1), .stall_cycles(sc1)
  );

  hazard_forward_ctrl #(.RA_W(5), .NUM_RS(2), .LU_PENALTY(3), .CNT_W(4)) u_p3 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_ready(mem_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .branch_flush(branch_flush), .stat_clr(stat_clr),
    .forward_sel(fs3), .pc_write_en(pc3), .ifid_write_en(if3),
    .idex_bubble(bub3), .pipe_freeze(frz3), .stall_cycles(sc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    id_rs_addr    = '0;
    id_rs_used    = '0;
    ex_rs_addr    = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    mem_rd        = '0;
    mem_reg_write = 1'b0;
    mem_mem_read  = 1'b0;
    mem_ready     = 1'b1;
    wb_rd         = '0;
    wb_reg_write  = 1'b0;
    branch_flush  = 1'b0;
    stat_clr      = 1'b0;
  endtask

  // Load x7 in EX, ID instruction reads x7 on operand 1
  task automatic hazard();
    ex_mem_read  = 1'b1;
    ex_reg_write = 1'b1;
    ex_rd        = 5'd7;
    id_rs_addr   = {5'd7, 5'd3};
    id_rs_used   = 2'b10;
  endtask

  // Start a new cycle: inputs change just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset, with hazard and freeze inputs active ----------
    rst_n = 1'b0;
    idle();
    hazard();
    mem_mem_read = 1'b1;
    mem_ready    = 1'b0;
    #3;
    chk("rst_pc", pc3, 1);
    chk("rst_ifid", if3, 1);
    chk("rst_bubble", bub3, 0);
    chk("rst_freeze", frz3, 0);
    chk("rst_sc3", sc3, 0);
    chk("rst_sc1", sc1, 0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;

    // ---------------- forwarding ------------------------------------------
    cyc(); mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    ex_rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("fwd_mem_prio", fs1, 4'b0010);

    cyc(); mem_rd = 5'd5; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("fwd_load_in_mem", fs1, 4'b0001);
    chk("fwd_load_no_freeze", frz1, 0);

    cyc(); mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    @(negedge clk);
    chk("fwd_x0", fs1, 4'b0000);

    cyc(); mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd9; wb_reg_write = 1'b1;
    ex_rs_addr = {5'd9, 5'd5};
    @(negedge clk);
    chk("fwd_two_ops", fs1, 4'b0110);
    chk("fwd_two_ops_p3", fs3, 4'b0110);

    cyc(); mem_rd = 5'd5; wb_rd = 5'd9; ex_rs_addr = {5'd9, 5'd5};
    @(negedge clk);
    chk("fwd_no_write", fs1, 4'b0000);

    // ---------------- load-use, P=1 and P=3 -------------------------------
    cyc(); stat_clr = 1'b1; @(negedge clk);
    cyc(); hazard(); @(negedge clk);
    chk("lu_bub1", bub1, 1);
    chk("lu_pc1", pc1, 0);
    chk("lu_ifid1", if1, 0);
    chk("lu_bub3_a", bub3, 1);
    cyc(); mem_rd = 5'd7; mem_reg_write = 1'b1; mem_mem_read = 1'b1; @(negedge clk);
    chk("lu_run1", bub1, 0);
    chk("lu_pc1_back", pc1, 1);
    chk("lu_bub3_b", bub3, 1);
    cyc(); wb_rd = 5'd7; wb_reg_write = 1'b1; ex_rs_addr = {5'd7, 5'd0}; @(negedge clk);
    chk("lu_fwd_wb", fs1, 4'b0100);
    chk("lu_bub3_c", bub3, 1);
    cyc(); @(negedge clk);
    chk("lu_bub3_done", bub3, 0);
    chk("lu_pc3_done", pc3, 1);
    chk("lu_sc3", sc3, 3);
    chk("lu_sc1", sc1, 1);

    // ---------------- memory wait during load-use stall (P=3) -------------
    nb = 0;
    cyc(); stat_clr = 1'b1; @(negedge clk);
    cyc(); hazard(); @(negedge clk);
    nb += int'(bub3);
    for (int k = 0; k < 4; k++) begin
      cyc(); mem_mem_read = 1'b1; mem_ready = 1'b0; @(negedge clk);
      chk("mw_freeze", frz3, 1);
      chk("mw_pc", pc3, 0);
      chk("mw_no_bubble", bub3, 0);
      nb += int'(bub3);
    end
    cyc(); mem_mem_read = 1'b1; @(negedge clk);
    chk("mw_release", frz3, 0);
    nb += int'(bub3);
    for (int k = 0; k < 3; k++) begin
      cyc(); @(negedge clk);
      nb += int'(bub3);
    end
    chk("mw_total_bubbles", nb, 3);
    chk("mw_sc3", sc3, 7);
    chk("mw_sc1", sc1, 5);

    // ---------------- branch flush ----------------------------------------
    cyc(); stat_clr = 1'b1; @(negedge clk);
    cyc(); hazard(); @(negedge clk);
    chk("bf_first_bub", bub3, 1);
    cyc(); branch_flush = 1'b1; @(negedge clk);
    chk("bf_abort_bub", bub3, 0);
    chk("bf_abort_pc", pc3, 1);
    cyc(); @(negedge clk);
    chk("bf_run_bub", bub3, 0);
    chk("bf_run_pc", pc3, 1);
    chk("bf_sc3", sc3, 1);
    cyc(); hazard(); branch_flush = 1'b1; @(negedge clk);
    chk("bf_over_lu", bub3, 0);
    chk("bf_over_lu_pc", pc1, 1);

    // ---------------- load-use boundaries ---------------------------------
    cyc(); hazard(); ex_rd = 5'd0; id_rs_addr = {5'd0, 5'd0}; id_rs_used = 2'b11;
    @(negedge clk);
    chk("lu_x0", bub1, 0);
    cyc(); hazard(); id_rs_used = 2'b00; @(negedge clk);
    chk("lu_unused", bub1, 0);
    cyc(); hazard(); ex_reg_write = 1'b0; @(negedge clk);
    chk("lu_no_regwrite", bub1, 0);
    cyc(); hazard(); id_rs_addr = {5'd3, 5'd7}; id_rs_used = 2'b01; @(negedge clk);
    chk("lu_op0", bub1, 1);
    repeat (3) cyc();

    // ---------------- async reset in MEM_WAIT -----------------------------
    cyc(); mem_mem_read = 1'b1; mem_ready = 1'b0; @(negedge clk);
    chk("ar_freeze", frz3, 1);
    cyc(); mem_mem_read = 1'b1; mem_ready = 1'b0; @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_freeze_rst", frz3, 0);
    chk("ar_pc_rst", pc3, 1);
    chk("ar_ifid_rst", if3, 1);
    chk("ar_bub_rst", bub3, 0);
    chk("ar_sc3_rst", sc3, 0);
    chk("ar_sc1_rst", sc1, 0);
    cyc(); rst_n = 1'b1; @(negedge clk);
    chk("ar_run_freeze", frz3, 0);
    chk("ar_run_pc", pc3, 1);

    // ---------------- counter saturation and clear ------------------------
    repeat (20) begin
      cyc(); mem_mem_read = 1'b1; mem_ready = 1'b0;
    end
    cyc(); mem_mem_read = 1'b1; mem_ready = 1'b0; stat_clr = 1'b1; @(negedge clk);
    chk("sat_sc3", sc3, 15);
    chk("sat_sc1", sc1, 20);
    cyc(); @(negedge clk);
    chk("clr_sc3", sc3, 0);
    chk("clr_sc1", sc1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
